axi_lite_mem_master: RTL and testbench
======================================

Name: axi_lite_mem_master

Overview:
Parametrised AXI4-Lite master that turns single load/store requests from the pipeline memory stage into AXI4-Lite transactions. Replaces the fixed 32-bit data-memory bridge with these additions: configurable data and address widths, a valid/ready request port with request latching, and a registered response carrying the raw RRESP/BRESP code. One transaction is in flight at a time. The block sits between the MEM stage and the data-side interconnect.

Parameters:
ADDR_W, 32, AXI address width (>= 12)
DATA_W, 32, AXI data width (32 or 64); STRB_W = DATA_W/8
PROT_VAL, 3'b000, constant driven on AWPROT/ARPROT

Ports:
ACLK  in  1  clock
ARST  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_wr  in  1  1=store, 0=load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data
req_strb  in  STRB_W  store byte enables
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  load data, valid with rsp_valid on loads
rsp_resp  out  2  RRESP/BRESP of the completed transaction
rsp_err  out  1  rsp_valid && rsp_resp != 2'b00
busy  out  1  state != IDLE
AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels, widths ADDR_W/DATA_W/STRB_W/2

Behaviour:
- Reset (ARST=1 at a clock edge): state=IDLE; all *VALID, BREADY, RREADY, rsp_valid, rsp_err = 0; rsp_rdata=0; rsp_resp=0; aw_done=w_done=0. req_ready is forced to 0 while ARST=1.
- req_ready = (state==IDLE) && !ARST. On acceptance, addr/wdata/strb/wr are latched. After that, req_* inputs are ignored until the block returns to IDLE.
- Address alignment: AWADDR/ARADDR = latched address with the low log2(STRB_W) bits cleared.
- AXI outputs depend only on state and the latched registers. No combinational path from req_* to AXI outputs.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA.
- IDLE: accept a write -> WR; accept a read -> RD_ADDR.
- WR: AWVALID=!aw_done and WVALID=!w_done, independent of each other. Each done flag sets on its handshake. Move to WR_RESP in the cycle both handshakes are complete, counting a same-cycle handshake. AW before W, W before AW and simultaneous ordering are all legal. BREADY=0 in WR.
- WR_RESP: BREADY=1. On BVALID: register rsp_resp=BRESP, pulse rsp_valid, go to IDLE.
- RD_ADDR: ARVALID=1, RREADY=0. On ARREADY -> RD_DATA.
- RD_DATA: RREADY=1. On RVALID: register rsp_rdata=RDATA and rsp_resp=RRESP, pulse rsp_valid, go to IDLE.
- Response timing: rsp_valid is registered and high for exactly the cycle after the B or R handshake. On a write, rsp_rdata holds its previous value.
- VALID stability: once a VALID is asserted, it and its payload stay stable until the handshake completes.
- Minimum latency with a zero-wait slave:
  - write: accept at cycle 0, AW+W at cycle 1, B at cycle 2, rsp_valid at cycle 3.
  - read: accept at 0, AR at 1, R at 2, rsp_valid at 3.
- The next request may be accepted in the same cycle rsp_valid is high, because state is already IDLE.
- Reset mid-transaction: everything is abandoned and outputs return to reset values. No response is produced for the in-flight request.
- Error codes: SLVERR (2'b10) and DECERR (2'b11) are reported as-is. EXOKAY is reported and flagged as rsp_err.

Optional Feature:
AXI_MEM_ERR_CNT_EN
- Defined: adds output err_cnt[15:0], plus input err_clr.
  - err_cnt increments on every rsp_valid with rsp_err=1 and saturates at 16'hFFFF.
  - err_clr=1 zeroes err_cnt; clear wins over a simultaneous increment.
  - ARST zeroes err_cnt.
- Undefined: no counter logic, and neither port exists.

Test Plan:
- Zero-wait write (addr 0x1006, wdata 0xDEADBEEF, strb 4'b1100): AWADDR=0x1004, AW and W together at cycle 1, B at cycle 2 -> rsp_valid at cycle 3 with rsp_resp=00 and rsp_err=0.
- Write with W ready 3 cycles before AWREADY: WVALID drops after its handshake, AWVALID held stable -> single B handshake, exactly one rsp_valid pulse.
- Read with ARREADY delayed 2 cycles, then RDATA=0x12345678 with RRESP=00: ARVALID/ARADDR stable while waiting -> rsp_rdata=0x12345678, one-cycle rsp_valid.
- Read returning RRESP=2'b10 (DATA_W=64, addr 0x2C): ARADDR=0x28 -> rsp_resp=10, rsp_err=1; with AXI_MEM_ERR_CNT_EN, err_cnt goes 0 -> 1.
- Back-to-back: issue a read with req_valid held high during the write's rsp_valid cycle -> read accepted in that same cycle; no bubble beyond the IDLE cycle.
- ARST asserted while in WR_RESP with BVALID low: all VALID/READY outputs at 0 next cycle, no rsp_valid, req_ready=1 the cycle after ARST deasserts.

Source files
------------

// File: rtl/axi_lite_mem_master_if.sv
// rtl/axi_lite_mem_master_if.sv - AXI4-Lite channel bundle between the memory-stage master and the interconnect
interface axi_lite_mem_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] AWADDR;
    logic [2:0]        AWPROT;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [2:0]        ARPROT;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_lite_mem_master.sv
// rtl/axi_lite_mem_master.sv - single-outstanding AXI4-Lite master for MEM-stage loads/stores
// Optional error counter (err_cnt/err_clr) built when AXI_MEM_ERR_CNT_EN is defined.
module axi_lite_mem_master #(
    parameter int         ADDR_W   = 32,
    parameter int         DATA_W   = 32,
    parameter logic [2:0] PROT_VAL = 3'b000,
    localparam int        STRB_W   = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_strb,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_err,
    output logic              busy,
    axi_lite_mem_master_if.master axi
`ifdef AXI_MEM_ERR_CNT_EN
    ,
    input  logic              err_clr,
    output logic [15:0]       err_cnt
`endif
);
    localparam int LSB = $clog2(STRB_W);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-LSB){1'b1}}, {LSB{1'b0}}};

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] strb_q;
    logic              aw_done;
    logic              w_done;
    logic              accept;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              ar_hs;
    logic              r_hs;

    assign accept = req_valid && req_ready;
    assign aw_hs  = axi.AWVALID && axi.AWREADY;
    assign w_hs   = axi.WVALID && axi.WREADY;
    assign b_hs   = axi.BVALID && axi.BREADY;
    assign ar_hs  = axi.ARVALID && axi.ARREADY;
    assign r_hs   = axi.RVALID && axi.RREADY;

    // Bus payload comes only from latched registers, never from req_*.
    assign axi.AWADDR = addr_q & ADDR_MASK;
    assign axi.ARADDR = addr_q & ADDR_MASK;
    assign axi.AWPROT = PROT_VAL;
    assign axi.ARPROT = PROT_VAL;
    assign axi.WDATA  = wdata_q;
    assign axi.WSTRB  = strb_q;

    assign busy    = (state != IDLE);
    assign rsp_err = rsp_valid && (rsp_resp != 2'b00);

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_wr ? WR : RD_ADDR;
            // A handshake landing this cycle counts as done.
            WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
            WR_RESP: if (b_hs) state_nxt = IDLE;
            RD_ADDR: if (ar_hs) state_nxt = RD_DATA;
            RD_DATA: if (r_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = 1'b0;
        axi.AWVALID = 1'b0;
        axi.WVALID  = 1'b0;
        axi.BREADY  = 1'b0;
        axi.ARVALID = 1'b0;
        axi.RREADY  = 1'b0;
        case (state)
            IDLE:    req_ready = !ARST;
            WR: begin
                axi.AWVALID = !aw_done;
                axi.WVALID  = !w_done;
            end
            WR_RESP: axi.BREADY  = 1'b1;
            RD_ADDR: axi.ARVALID = 1'b1;
            RD_DATA: axi.RREADY  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
        end else begin
            rsp_valid <= b_hs || r_hs;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                strb_q  <= req_strb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (state == WR) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (b_hs) rsp_resp <= axi.BRESP;
            if (r_hs) begin
                rsp_resp  <= axi.RRESP;
                rsp_rdata <= axi.RDATA;
            end
        end
    end

`ifdef AXI_MEM_ERR_CNT_EN
    // Clear has priority over a same-cycle error count.
    always_ff @(posedge ACLK) begin
        if (ARST || err_clr) begin
            err_cnt <= 16'h0000;
        end else if (rsp_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_axi_lite_mem_master.sv
// tb/tb_axi_lite_mem_master.sv - scoreboard bench for axi_lite_mem_master (32-bit and 64-bit instances)
module tb_axi_lite_mem_master;
    typedef struct packed {
        logic [1:0]  resp;
        logic [63:0] rdata;
    } exp_t;

    logic        clk;
    logic        arst;
    logic        req_valid, req_wr, req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_strb;
    logic [1:0]  rsp_resp;

    logic        r64_valid, r64_wr, r64_ready, r64_rsp_valid, r64_err, r64_busy;
    logic [31:0] r64_addr;
    logic [63:0] r64_wdata, r64_rdata;
    logic [7:0]  r64_strb;
    logic [1:0]  r64_resp;
`ifdef AXI_MEM_ERR_CNT_EN
    logic        err_clr, err_clr64;
    logic [15:0] err_cnt, err_cnt64;
`endif

    logic        nxt_wr;
    logic [31:0] nxt_addr, nxt_wdata;
    logic [3:0]  nxt_strb;
    logic [31:0] mdl_rdata;
    exp_t        sb_q[$];
    int          total;
    int          bad;

    axi_lite_mem_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    axi_lite_mem_master_if #(.ADDR_W(32), .DATA_W(64)) bus64 ();

    axi_lite_mem_master #(.ADDR_W(32), .DATA_W(32), .PROT_VAL(3'b000)) dut (
        .ACLK(clk), .ARST(arst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_err(rsp_err), .busy(busy), .axi(bus)
`ifdef AXI_MEM_ERR_CNT_EN
        , .err_clr(err_clr), .err_cnt(err_cnt)
`endif
    );

    axi_lite_mem_master #(.ADDR_W(32), .DATA_W(64), .PROT_VAL(3'b000)) dut64 (
        .ACLK(clk), .ARST(arst),
        .req_valid(r64_valid), .req_ready(r64_ready), .req_wr(r64_wr),
        .req_addr(r64_addr), .req_wdata(r64_wdata), .req_strb(r64_strb),
        .rsp_valid(r64_rsp_valid), .rsp_rdata(r64_rdata), .rsp_resp(r64_resp),
        .rsp_err(r64_err), .busy(r64_busy), .axi(bus64)
`ifdef AXI_MEM_ERR_CNT_EN
        , .err_clr(err_clr64), .err_cnt(err_cnt64)
`endif
    );

    always #5 clk = ~clk;

    task automatic clear_slaves();
        bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0;
        bus.ARREADY = 0; bus.RVALID = 0; bus.RRESP = 0; bus.RDATA = 0;
        bus64.AWREADY = 0; bus64.WREADY = 0; bus64.BVALID = 0; bus64.BRESP = 0;
        bus64.ARREADY = 0; bus64.RVALID = 0; bus64.RRESP = 0; bus64.RDATA = 0;
    endtask

    // One transaction on the 32-bit DUT; k counts clock edges after the accept edge.
    task automatic run_txn(input string name, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int a_wait, input int w_wait, input logic [1:0] resp,
                           input logic [31:0] rdata, input bit pre_driven, input bit chain_next,
                           output int rsp_k);
        logic [31:0] exp_addr;
        bit a_hs, w_hs, d_hs, done;
        exp_t e;
        exp_addr = addr & 32'hFFFF_FFFC;
        a_hs = 0; w_hs = 0; d_hs = 0; done = 0; rsp_k = -1;
        if (!pre_driven) begin
            @(negedge clk);
            req_valid = 1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_strb = strb;
        end
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL %s accept: req_ready=%b want 1", name, req_ready); end
        if (!wr) mdl_rdata = rdata;
        e.resp = resp; e.rdata = {32'h0, mdl_rdata};
        sb_q.push_back(e);
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 0; req_wr = ~wr; req_addr = ~addr; req_wdata = ~wdata; req_strb = ~strb;
            end
            if (d_hs) begin
                clear_slaves();
                rsp_k = k; done = 1;
                total++;
                if (rsp_valid !== 1'b1) begin
                    bad++; $display("FAIL %s rsp_valid: got %b want 1", name, rsp_valid);
                end else if (sb_q.size() == 0) begin
                    bad++; $display("FAIL %s scoreboard empty on response", name);
                end else begin
                    e = sb_q.pop_front();
                    total++;
                    if (rsp_resp !== e.resp || rsp_err !== (e.resp != 2'b00)) begin
                        bad++; $display("FAIL %s resp: got %b/%b want %b/%b", name, rsp_resp, rsp_err, e.resp, e.resp != 2'b00);
                    end
                    total++;
                    if (rsp_rdata !== e.rdata[31:0]) begin
                        bad++; $display("FAIL %s rdata: got %h want %h", name, rsp_rdata, e.rdata[31:0]);
                    end
                end
                if (chain_next) begin
                    req_valid = 1; req_wr = nxt_wr; req_addr = nxt_addr; req_wdata = nxt_wdata; req_strb = nxt_strb;
                end
            end else begin
                total++;
                if (rsp_valid !== 1'b0) begin bad++; $display("FAIL %s early rsp_valid at k=%0d", name, k); end
                if (wr) begin
                    total++;
                    if (bus.AWVALID !== !a_hs || bus.WVALID !== !w_hs || bus.BREADY !== (a_hs && w_hs) || bus.ARVALID !== 1'b0) begin
                        bad++; $display("FAIL %s wr ctl k=%0d: aw=%b w=%b b=%b ar=%b want %b %b %b 0",
                                        name, k, bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, !a_hs, !w_hs, a_hs && w_hs);
                    end
                    if (bus.AWVALID) begin
                        total++;
                        if (bus.AWADDR !== exp_addr) begin bad++; $display("FAIL %s AWADDR: got %h want %h", name, bus.AWADDR, exp_addr); end
                    end
                    if (bus.WVALID) begin
                        total++;
                        if (bus.WDATA !== wdata || bus.WSTRB !== strb) begin
                            bad++; $display("FAIL %s W payload: got %h/%b want %h/%b", name, bus.WDATA, bus.WSTRB, wdata, strb);
                        end
                    end
                    bus.AWREADY = (k > a_wait);
                    bus.WREADY  = (k > w_wait);
                    if (a_hs && w_hs) begin bus.BVALID = 1; bus.BRESP = resp; end
                    if (bus.BVALID && bus.BREADY) d_hs = 1;
                    if (bus.AWVALID && bus.AWREADY) a_hs = 1;
                    if (bus.WVALID && bus.WREADY) w_hs = 1;
                end else begin
                    total++;
                    if (bus.ARVALID !== !a_hs || bus.RREADY !== a_hs || bus.AWVALID !== 1'b0 || bus.WVALID !== 1'b0) begin
                        bad++; $display("FAIL %s rd ctl k=%0d: ar=%b r=%b aw=%b w=%b want %b %b 0 0",
                                        name, k, bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, !a_hs, a_hs);
                    end
                    if (bus.ARVALID) begin
                        total++;
                        if (bus.ARADDR !== exp_addr) begin bad++; $display("FAIL %s ARADDR: got %h want %h", name, bus.ARADDR, exp_addr); end
                    end
                    bus.ARREADY = (k > a_wait);
                    if (a_hs) begin bus.RVALID = 1; bus.RDATA = rdata; bus.RRESP = resp; end
                    if (bus.RVALID && bus.RREADY) d_hs = 1;
                    if (bus.ARVALID && bus.ARREADY) a_hs = 1;
                end
            end
        end
        if (!done) begin
            total++; bad++; $display("FAIL %s timeout: no response within budget", name);
            clear_slaves();
        end
        if (!chain_next) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0) begin bad++; $display("FAIL %s rsp_valid pulse too long: got %b want 0", name, rsp_valid); end
        end
    endtask

    task automatic test_reset();
        arst = 1;
        repeat (2) @(negedge clk);
        total++;
        if (req_ready !== 1'b0 || r64_ready !== 1'b0) begin bad++; $display("FAIL reset req_ready: got %b/%b want 0/0", req_ready, r64_ready); end
        total++;
        if ({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY} !== 5'b0) begin
            bad++; $display("FAIL reset bus ctl: got %b want 00000", {bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY});
        end
        total++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset rsp: got v=%b e=%b r=%b d=%h busy=%b want all 0", rsp_valid, rsp_err, rsp_resp, rsp_rdata, busy);
        end
        total++;
        if (r64_rsp_valid !== 1'b0 || r64_err !== 1'b0 || r64_resp !== 2'b00 || r64_rdata !== 64'h0 || r64_busy !== 1'b0) begin
            bad++; $display("FAIL reset rsp64: got v=%b d=%h busy=%b want 0", r64_rsp_valid, r64_rdata, r64_busy);
        end
        total++;
        if (bus.AWPROT !== 3'b000 || bus.ARPROT !== 3'b000) begin bad++; $display("FAIL reset prot: got %b/%b want 000", bus.AWPROT, bus.ARPROT); end
`ifdef AXI_MEM_ERR_CNT_EN
        total++;
        if (err_cnt !== 16'h0 || err_cnt64 !== 16'h0) begin bad++; $display("FAIL reset err_cnt: got %h/%h want 0", err_cnt, err_cnt64); end
`endif
        arst = 0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL post-reset req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_zero_wait_write();
        int lat;
        run_txn("zw_write", 1, 32'h1006, 32'hDEADBEEF, 4'b1100, 0, 0, 2'b00, 32'h0, 0, 0, lat);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL zw_write latency: got %0d want 3", lat); end
    endtask

    task automatic test_write_orders();
        int lat;
        run_txn("w_first", 1, 32'h2000, 32'hA5A5_0F0F, 4'hF, 3, 0, 2'b00, 32'h0, 0, 0, lat);
        total++;
        if (lat !== 6) begin bad++; $display("FAIL w_first latency: got %0d want 6", lat); end
        run_txn("aw_first", 1, 32'h2013, 32'h0BAD_F00D, 4'b0010, 0, 2, 2'b00, 32'h0, 0, 0, lat);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL aw_first latency: got %0d want 5", lat); end
    endtask

    task automatic test_read_delayed();
        int lat;
        run_txn("rd_wait", 0, 32'h3000, 32'h0, 4'h0, 2, 0, 2'b00, 32'h12345678, 0, 0, lat);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL rd_wait latency: got %0d want 5", lat); end
    endtask

    task automatic test_write_exokay();
        int lat;
        run_txn("exokay_wr", 1, 32'h44, 32'h1, 4'h1, 0, 0, 2'b01, 32'h0, 0, 0, lat);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL exokay_wr latency: got %0d want 3", lat); end
    endtask

    task automatic test_back_to_back();
        int lat_w, lat_r;
        nxt_wr = 0; nxt_addr = 32'h507; nxt_wdata = 32'h0; nxt_strb = 4'h0;
        run_txn("b2b_wr", 1, 32'h500, 32'h77, 4'h3, 0, 0, 2'b00, 32'h0, 0, 1, lat_w);
        run_txn("b2b_rd", 0, 32'h507, 32'h0, 4'h0, 0, 0, 2'b11, 32'hBEEF_0001, 1, 0, lat_r);
        total++;
        if (lat_w !== 3 || lat_r !== 3) begin bad++; $display("FAIL b2b latency: got %0d/%0d want 3/3", lat_w, lat_r); end
    endtask

    task automatic test_read_err64();
        exp_t e;
        @(negedge clk);
        r64_valid = 1; r64_wr = 0; r64_addr = 32'h2C; bus64.ARREADY = 1;
        total++;
        if (r64_ready !== 1'b1) begin bad++; $display("FAIL rd64 accept: req_ready=%b want 1", r64_ready); end
`ifdef AXI_MEM_ERR_CNT_EN
        total++;
        if (err_cnt64 !== 16'h0) begin bad++; $display("FAIL rd64 err_cnt before: got %h want 0", err_cnt64); end
`endif
        e.resp = 2'b10; e.rdata = 64'h0123_4567_89AB_CDEF;
        sb_q.push_back(e);
        @(negedge clk);
        r64_valid = 0; r64_addr = 32'hFFF;
        total++;
        if (bus64.ARVALID !== 1'b1 || bus64.ARADDR !== 32'h28) begin
            bad++; $display("FAIL rd64 AR: got v=%b a=%h want 1/00000028", bus64.ARVALID, bus64.ARADDR);
        end
        @(negedge clk);
        total++;
        if (bus64.ARVALID !== 1'b0 || bus64.RREADY !== 1'b1) begin
            bad++; $display("FAIL rd64 RD_DATA: got ar=%b r=%b want 0/1", bus64.ARVALID, bus64.RREADY);
        end
        bus64.ARREADY = 0; bus64.RVALID = 1; bus64.RDATA = 64'h0123_4567_89AB_CDEF; bus64.RRESP = 2'b10;
        @(negedge clk);
        bus64.RVALID = 0;
        total++;
        if (r64_rsp_valid !== 1'b1) begin
            bad++; $display("FAIL rd64 rsp_valid: got %b want 1", r64_rsp_valid);
        end else if (sb_q.size() == 0) begin
            bad++; $display("FAIL rd64 scoreboard empty on response");
        end else begin
            e = sb_q.pop_front();
            total++;
            if (r64_resp !== e.resp || r64_rdata !== e.rdata || r64_err !== (e.resp != 2'b00)) begin
                bad++; $display("FAIL rd64 rsp: got %b/%h/%b want %b/%h/%b", r64_resp, r64_rdata, r64_err, e.resp, e.rdata, e.resp != 2'b00);
            end
        end
        @(negedge clk);
        total++;
        if (r64_rsp_valid !== 1'b0) begin bad++; $display("FAIL rd64 pulse too long: got %b want 0", r64_rsp_valid); end
`ifdef AXI_MEM_ERR_CNT_EN
        total++;
        if (err_cnt64 !== 16'h1) begin bad++; $display("FAIL rd64 err_cnt after: got %h want 1", err_cnt64); end
        err_clr64 = 1;
        @(negedge clk);
        err_clr64 = 0;
        total++;
        if (err_cnt64 !== 16'h0) begin bad++; $display("FAIL err_clr: got %h want 0", err_cnt64); end
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1; req_wr = 1; req_addr = 32'h40; req_wdata = 32'h55; req_strb = 4'hF;
        bus.AWREADY = 1; bus.WREADY = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        total++;
        if (bus.BREADY !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid reach WR_RESP: BREADY=%b busy=%b want 1/1", bus.BREADY, busy); end
        arst = 1;
        @(negedge clk);
        total++;
        if ({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY} !== 5'b0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL mid reset ctl: got %b req_ready=%b want 00000/0",
                            {bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY}, req_ready);
        end
        total++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00 || busy !== 1'b0) begin
            bad++; $display("FAIL mid reset rsp: got v=%b d=%h r=%b busy=%b want 0", rsp_valid, rsp_rdata, rsp_resp, busy);
        end
        arst = 0;
        clear_slaves();
        mdl_rdata = 32'h0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL mid post-reset: req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    initial begin
        clk = 0; arst = 1; total = 0; bad = 0; mdl_rdata = 32'h0;
        req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; req_strb = 0;
        r64_valid = 0; r64_wr = 0; r64_addr = 0; r64_wdata = 0; r64_strb = 0;
        nxt_wr = 0; nxt_addr = 0; nxt_wdata = 0; nxt_strb = 0;
`ifdef AXI_MEM_ERR_CNT_EN
        err_clr = 0; err_clr64 = 0;
`endif
        clear_slaves();
        test_reset();
        test_zero_wait_write();
        test_write_orders();
        test_read_delayed();
        test_write_exokay();
        test_back_to_back();
        test_read_err64();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
